// File: rtl/add_share_arbiter.sv
// ---------------------------------------------------------------------------
// add_share_arbiter
//
// Shares one 32-bit adder between NREQ requesters. Each cycle at most one
// valid requester is granted, using a round-robin pointer. The granted
// operands are summed. The sum, the Zero/Overflow/Negative flags and the
// requester tag are captured in a one-entry output register. That register
// drains through an out_valid/out_ready handshake.
//
// Build option:
//   ADD_SHARE_FIXED_PRIO_EN - when defined, the round-robin pointer is
//   removed and the lowest-index valid requester always wins.
//
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   req_valid       - [NREQ]      per-requester request valid
//   req_ready       - [NREQ]      per-requester accept (one-hot or zero)
//   req_a, req_b    - [32*NREQ]   operands, requester i at [32i+31:32i]
//   req_signed      - [NREQ]      1 = signed add, 0 = unsigned add
//   out_valid       - result register holds a valid result
//   out_ready       - consumer takes the result
//   out_id          - [IDW]       requester that owns the result
//   out_s           - [32]        A+B mod 2^32
//   out_zero/ovf/neg- result flags
// ---------------------------------------------------------------------------
module add_share_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDW-1:0]       out_id,
    output logic [31:0]          out_s,
    output logic                 out_zero,
    output logic                 out_ovf,
    output logic                 out_neg
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] id_q, id_d;
    logic [31:0]    s_q, s_d;
    logic           zero_q, zero_d;
    logic           ovf_q, ovf_d;
    logic           neg_q, neg_d;

    // Unpack the operand buses so that the selection mux is a plain loop.
    logic [31:0] a_arr [NREQ];
    logic [31:0] b_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[32*gi +: 32];
            assign b_arr[gi] = req_b[32*gi +: 32];
        end
    endgenerate

    logic [NREQ-1:0] grant_oh;
    logic [IDW-1:0]  grant_id;
    logic            grant_any;
    logic            can_accept;
    logic            accept;

`ifndef ADD_SHARE_FIXED_PRIO_EN
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
`endif

    // ---------------- arbitration ----------------
    always_comb begin
        grant_oh  = '0;
        grant_id  = '0;
        grant_any = 1'b0;
`ifdef ADD_SHARE_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && req_valid[i]) begin
                grant_any   = 1'b1;
                grant_oh[i] = 1'b1;
                grant_id    = IDW'(i);
            end
        end
`else
        // Two passes: first look at indices at or above the pointer. If
        // none is valid, the second pass wraps and takes the lowest valid
        // index.
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && req_valid[i] && (IDW'(i) >= rr_ptr_q)) begin
                grant_any   = 1'b1;
                grant_oh[i] = 1'b1;
                grant_id    = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && req_valid[i]) begin
                grant_any   = 1'b1;
                grant_oh[i] = 1'b1;
                grant_id    = IDW'(i);
            end
        end
`endif
    end

    assign can_accept = (state_q == ST_EMPTY) | out_ready;
    assign req_ready  = (rst_n && can_accept) ? grant_oh : '0;
    assign accept     = grant_any & can_accept & rst_n;

    // ---------------- shared adder ----------------
    logic [31:0] a_sel, b_sel, sum;
    logic        sgn_sel, ovf_s, ovf_u, ovf_c;

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        sgn_sel = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_oh[i]) begin
                a_sel   = a_arr[i];
                b_sel   = b_arr[i];
                sgn_sel = req_signed[i];
            end
        end
    end

    assign sum   = a_sel + b_sel;
    assign ovf_s = (a_sel[31] & b_sel[31] & ~sum[31]) | (~a_sel[31] & ~b_sel[31] & sum[31]);
    // Carry out of bit 31, rebuilt from the MSBs so the adder stays 32 bits.
    assign ovf_u = (a_sel[31] & b_sel[31]) | (a_sel[31] & ~sum[31]) | (b_sel[31] & ~sum[31]);
    assign ovf_c = sgn_sel ? ovf_s : ovf_u;

    // ---------------- result register FSM ----------------
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        s_d     = s_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        neg_d   = neg_q;
`ifndef ADD_SHARE_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        if (accept) begin
            state_d = ST_FULL;
            id_d    = grant_id;
            s_d     = sum;
            ovf_d   = ovf_c;
            zero_d  = (sum == 32'd0) & ~ovf_c;
            // When the operand signs match, the true sign is the operand
            // sign, even if the 32-bit sum overflowed.
            neg_d   = sgn_sel & ((a_sel[31] ^ b_sel[31]) ? sum[31] : a_sel[31]);
`ifndef ADD_SHARE_FIXED_PRIO_EN
            rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
`endif
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            id_q     <= '0;
            s_q      <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
`ifndef ADD_SHARE_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            s_q      <= s_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
`ifndef ADD_SHARE_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_id    = id_q;
    assign out_s     = s_q;
    assign out_zero  = zero_q;
    assign out_ovf   = ovf_q;
    assign out_neg   = neg_q;

endmodule

// File: doc/add_share_arbiter.md
# add_share_arbiter

Shares a single 32-bit adder between up to NREQ requesters (e.g. ALU add path, branch-target calc, load/store address calc) under round-robin arbitration with valid/ready handshakes. Each accepted request is computed on the shared adder and the sum plus Zero/Overflow/Negative flags are returned through a one-entry output register tagged with the requester index. Sits between the requesting pipeline stages and the adder datapath.

## Interface
- NREQ, 2, number of requesters (2..8)
- IDW, 3, width of requester tag; must satisfy 2^IDW >= NREQ
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_a  in  32*NREQ  operand A, requester i at bits [32i+31:32i]
- req_b  in  32*NREQ  operand B, same packing
- req_signed  in  NREQ  per-requester signed/unsigned select
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  consumer accepts result
- out_id  out  IDW  index of requester owning the result
- out_s  out  32  sum A+B mod 2^32
- out_zero  out  1  Zero flag
- out_ovf  out  1  Overflow flag
- out_neg  out  1  Negative flag

## Operation
- States: EMPTY (out_valid=0), FULL (out_valid=1).
- can_accept = !out_valid | out_ready.
- Grant: among asserted req_valid, first index at or after rr_ptr (wrapping NREQ-1 -> 0). req_ready[g]=can_accept for winner g; all other bits 0. No grant when no req_valid.
- Accept (req_valid[g] & req_ready[g]): register S, flags, out_id=g; out_valid=1; rr_ptr <= (g+1) mod NREQ.
- No accept and out_valid & out_ready: out_valid <= 0 (FULL -> EMPTY); data registers hold.
- Accept and out_ready same cycle: result replaced, out_valid stays 1 (FULL -> FULL), back-to-back throughput 1/cycle.
- out_valid & !out_ready: all out_* held stable; req_ready all 0; rr_ptr unchanged.
- Flags (computed on accepted operands):
  - signed overflow = (A31 & B31 & ~S31) | (~A31 & ~B31 & S31)
  - unsigned overflow = carry out of bit 31 = (A31&B31)|(A31&~S31)|(B31&~S31)
  - Zero = (S==0) & ~Overflow
  - Negative = Signed & ((A31^B31) ? S31 : A31); always 0 unsigned
- req_valid may drop without being granted; no requester state is kept.

## Timing
- Reset (rst_n=0 at edge): out_valid=0, out_id=0, out_s=0, out_zero=0, out_ovf=0, out_neg=0, rr_ptr=0. req_ready=0 while rst_n=0.
- Reset mid-operation: held result discarded, no out_valid on first cycle after release; pending requests re-arbitrated from rr_ptr=0.
- Latency: request accepted at edge N appears on out_* in the cycle after edge N (1 cycle).
- req_ready is combinational from req_valid, out_valid, out_ready, rr_ptr; no combinational path from req_a/req_b to any output.
- out_* registered only.

## Configuration
- ADD_SHARE_FIXED_PRIO_EN defined: rr_ptr removed; lowest-index asserted requester always wins; everything else unchanged.
- Undefined (default): round-robin as above.

## Test plan
- Reset: hold rst_n=0 3 cycles with all req_valid=1 -> req_ready=0, out_valid=0, all out_* 0; first grant after release to requester 0.
- Single signed add: req 1 A=0x7FFFFFFF B=0x00000001 signed -> next cycle out_valid=1, out_id=1, out_s=0x80000000, out_ovf=1, out_zero=0, out_neg=0.
- Unsigned wrap: A=0xFFFFFFFF B=0x00000001 unsigned -> out_s=0, out_ovf=1, out_zero=0, out_neg=0; A=5 B=0xFFFFFFFB signed -> out_s=0, out_zero=1, out_ovf=0.
- Round-robin fairness: NREQ=3, all req_valid held high, out_ready=1 -> out_id sequence 0,1,2,0,1,2 one per cycle; with ADD_SHARE_FIXED_PRIO_EN -> 0,0,0,...
- Backpressure: out_ready=0 for 4 cycles after a result -> out_* stable, req_ready=0; raise out_ready -> new result loaded same edge, out_valid stays 1.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, result never delivered.
